cla_div8_seq: RTL

Sequential 8-bit unsigned restoring divider for the CLA datapath. It performs one trial subtraction per clock, forming the borrow with a generate/propagate borrow-lookahead network, the subtract-direction counterpart of the adder's carry lookahead. The block sits beside the 8-bit CLA adder in the arithmetic unit. It uses a start/done handshake and holds its results until the next accepted start.

---
 rtl/cla_div8_seq_if.sv | 23 ++
 rtl/cla_div8_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cla_div8_seq_if.sv
// Start/done handshake bundle between a requester and the sequential divider.
interface cla_div8_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/cla_div8_seq.sv
// Sequential unsigned restoring divider, one trial subtraction per clock.
// The trial subtract forms its borrows with a 4-bit-group borrow-lookahead
// network, mirroring the carry lookahead of the neighbouring CLA adder.
module cla_div8_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    cla_div8_seq_if.slave bus
);
    localparam int unsigned N  = WIDTH + 1;
    localparam int unsigned NG = (N + 3) / 4;
    localparam int unsigned NB = NG * 4;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    // The partial remainder stays below the divisor after every step, so its
    // top trial bit is always zero once the restore decision is made; only
    // the low WIDTH bits are kept.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic [N-1:0]     s_c;
    logic [N-1:0]     dv_c;
    logic [NB-1:0]    g_pad;
    logic [NB-1:0]    p_pad;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_b;
    logic [WIDTH-1:0] b_bit;
    logic [WIDTH-1:0] diff_c;
    logic             borrow_out;
    logic             term;
    logic             acc;

    assign s_c  = {r_q, q_q[WIDTH-1]};
    assign dv_c = {1'b0, d_q};

    // Borrow-lookahead trial subtract S - {0,D}, borrow-in 0.
    always_comb begin
        g_pad = '0;
        p_pad = '1;
        g_pad[N-1:0] = ~s_c & dv_c;
        p_pad[N-1:0] = ~(s_c ^ dv_c);
        grp_g = '0;
        grp_p = '1;
        grp_b = '0;
        b_bit = '0;
        term  = 1'b0;
        acc   = 1'b0;
        // group generate/propagate
        for (int j = 0; j < int'(NG); j++) begin
            for (int k = 0; k < 4; k++) begin
                grp_g[j] = g_pad[4*j+k] | (p_pad[4*j+k] & grp_g[j]);
                grp_p[j] = grp_p[j] & p_pad[4*j+k];
            end
        end
        // flat sum-of-products borrow into each group
        for (int j = 1; j < int'(NG); j++) begin
            acc = 1'b0;
            for (int k = 0; k < j; k++) begin
                term = grp_g[k];
                for (int m = k + 1; m < j; m++) begin
                    term = term & grp_p[m];
                end
                acc = acc | term;
            end
            grp_b[j] = acc;
        end
        // flat sum-of-products borrow into each bit from its group borrow-in
        for (int i = 0; i < int'(WIDTH); i++) begin
            acc = grp_b[i/4];
            for (int l = (i/4)*4; l < i; l++) begin
                acc = acc & p_pad[l];
            end
            for (int l = (i/4)*4; l < i; l++) begin
                term = g_pad[l];
                for (int m = l + 1; m < i; m++) begin
                    term = term & p_pad[m];
                end
                acc = acc | term;
            end
            b_bit[i] = acc;
        end
        borrow_out = grp_g[NG-1] | (grp_p[NG-1] & grp_b[NG-1]);
        diff_c     = s_c[WIDTH-1:0] ^ dv_c[WIDTH-1:0] ^ b_bit;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    // Next-state, datapath update and registered handshake outputs.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        state_d = S_RUN;
                        q_d     = bus.dividend;
                        d_d     = bus.divisor;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH);
                        dbz_d   = 1'b0;
                    end else begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end
                end
            end
            S_RUN: begin
                r_d   = borrow_out ? s_c[WIDTH-1:0] : diff_c;
                q_d   = {q_q[WIDTH-2:0], ~borrow_out};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = S_DONE;
                    quotient_d  = q_d;
                    remainder_d = r_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule
